// File: rtl/sram_rw_sched.sv
// sram_rw_sched: schedules a write channel and a read channel onto one
// single-port SRAM RW0 port. Writes have priority over reads. After a read
// has been blocked for STARVE_LIM cycles in a row, reads take priority.
// Read data returns through a small response FIFO. The FIFO cannot
// overflow because the scheduler only accepts a read while
// (reads accepted but not yet popped) < RESP_DEPTH.
// Optional build macro: SRAM_RW_SCHED_OUTREG_EN registers all RW0 outputs.
// This adds one cycle of read latency and raises the minimum RESP_DEPTH
// to 4.
module sram_rw_sched #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 96,
   parameter int MASK_W     = 16,
   parameter int RESP_DEPTH = 3,
   parameter int STARVE_LIM = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [MASK_W-1:0] w_mask,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [DATA_W-1:0] RW0_wdata,
   output logic [MASK_W-1:0] RW0_wmask,
   input  logic [DATA_W-1:0] RW0_rdata
);

`ifdef SRAM_RW_SCHED_OUTREG_EN
   localparam int MIN_DEPTH = 4;
   localparam int LAT_STG   = 2;
`else
   localparam int MIN_DEPTH = 3;
   localparam int LAT_STG   = 1;
`endif
   localparam int         PTR_W    = $clog2(RESP_DEPTH);
   localparam logic [3:0] DEPTH_C  = 4'(RESP_DEPTH);
   localparam logic [3:0] STARVE_C = 4'(STARVE_LIM);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

   if (RESP_DEPTH < MIN_DEPTH || RESP_DEPTH > 8) begin : g_bad_depth
      $error("sram_rw_sched: RESP_DEPTH %0d out of range %0d..8", RESP_DEPTH, MIN_DEPTH);
   end
   if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_starve
      $error("sram_rw_sched: STARVE_LIM %0d out of range 1..15", STARVE_LIM);
   end

   logic [3:0]         cnt_q, cnt_d;
   logic [3:0]         starve_q, starve_d;
   logic [LAT_STG-1:0] inflight_q;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [3:0]         occ_q;
   logic [DATA_W-1:0]  mem_q [RESP_DEPTH];

   logic              rd_ok, w_gnt, r_gnt, push, pop;
   logic              rw_en_d, rw_wmode_d;
   logic [ADDR_W-1:0] rw_addr_d;
   logic [DATA_W-1:0] rw_wdata_d;
   logic [MASK_W-1:0] rw_wmask_d;

   assign rd_ok      = (cnt_q < DEPTH_C);
   assign w_gnt      = w_valid && w_ready;
   assign r_gnt      = r_valid && r_ready;
   assign push       = inflight_q[LAT_STG-1];
   assign resp_valid = (occ_q != 4'd0);
   assign resp_data  = mem_q[rd_ptr_q];
   assign pop        = resp_valid && resp_ready;

   // Arbitration: writes win unless reads have been starved long enough.
   always_comb begin
      w_ready = 1'b1;
      r_ready = rd_ok && !w_valid;
      if (starve_q == STARVE_C) begin
         r_ready = rd_ok;
         w_ready = !(r_valid && rd_ok);
      end
   end

   // Next outstanding-read count and starvation counter.
   always_comb begin
      cnt_d = cnt_q;
      if (r_gnt && !pop) begin
         cnt_d = cnt_q + 4'd1;
      end else if (pop && !r_gnt) begin
         cnt_d = cnt_q - 4'd1;
      end
      starve_d = starve_q;
      if (!r_valid || r_gnt) begin
         starve_d = 4'd0;
      end else if (rd_ok && w_valid && starve_q != STARVE_C) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // SRAM command for the granted channel. All fields are zero when idle.
   always_comb begin
      rw_en_d    = w_gnt || r_gnt;
      rw_wmode_d = w_gnt;
      rw_addr_d  = '0;
      rw_wdata_d = '0;
      rw_wmask_d = '0;
      if (w_gnt) begin
         rw_addr_d  = w_addr;
         rw_wdata_d = w_data;
         rw_wmask_d = w_mask;
      end else if (r_gnt) begin
         rw_addr_d  = r_addr;
      end
   end

`ifdef SRAM_RW_SCHED_OUTREG_EN
   // Registered SRAM command.
   always_ff @(posedge clock) begin
      if (reset) begin
         RW0_en    <= 1'b0;
         RW0_wmode <= 1'b0;
         RW0_addr  <= '0;
         RW0_wdata <= '0;
         RW0_wmask <= '0;
      end else begin
         RW0_en    <= rw_en_d;
         RW0_wmode <= rw_wmode_d;
         RW0_addr  <= rw_addr_d;
         RW0_wdata <= rw_wdata_d;
         RW0_wmask <= rw_wmask_d;
      end
   end
`else
   assign RW0_en    = rw_en_d;
   assign RW0_wmode = rw_wmode_d;
   assign RW0_addr  = rw_addr_d;
   assign RW0_wdata = rw_wdata_d;
   assign RW0_wmask = rw_wmask_d;
`endif

   // Control state: counters, in-flight read tracker, FIFO pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q      <= '0;
         starve_q   <= '0;
         inflight_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
      end else begin
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
`ifdef SRAM_RW_SCHED_OUTREG_EN
         inflight_q <= {inflight_q[0], r_gnt};
`else
         inflight_q <= r_gnt;
`endif
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            occ_q <= occ_q + 4'd1;
         end else if (pop && !push) begin
            occ_q <= occ_q - 4'd1;
         end
      end
   end

   // Response storage. The data path needs no reset.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         mem_q[wr_ptr_q] <= RW0_rdata;
      end
   end

endmodule

// File: tb/tb_sram_rw_sched.sv
// tb_sram_rw_sched: directed plus randomized checks of sram_rw_sched
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_sram_rw_sched;

`ifdef SRAM_RW_SCHED_OUTREG_EN
   localparam int DEPTH = 4;
   localparam int LAT   = 3;
`else
   localparam int DEPTH = 3;
   localparam int LAT   = 2;
`endif
   localparam int LIM = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        w_valid, r_valid, resp_ready;
   logic [11:0] w_addr, r_addr;
   logic [95:0] w_data;
   logic [15:0] w_mask;
   logic        w_ready, r_ready, resp_valid;
   logic [95:0] resp_data;
   logic [11:0] RW0_addr;
   logic        RW0_en, RW0_wmode;
   logic [95:0] RW0_wdata, RW0_rdata;
   logic [15:0] RW0_wmask;

   always #5 clock = ~clock;

   sram_rw_sched #(.RESP_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
      .clock(clock), .reset(reset),
      .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
      .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
      .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
   );

   function automatic logic [95:0] init_word(input int i);
      return {32'(i * 32'h9E3779B1), 32'(i ^ 32'h5A5A5A5A), 32'(i * 7 + 3)};
   endfunction

   function automatic logic [95:0] apply_mask(input logic [95:0] old_v, input logic [95:0] new_v,
                                              input logic [15:0] m);
      logic [95:0] r;
      r = old_v;
      for (int g = 0; g < 16; g++) begin
         if (m[g]) r[g*6 +: 6] = new_v[g*6 +: 6];
      end
      return r;
   endfunction

   // SRAM behavioural model with one-cycle read latency.
   logic [95:0] sram_mem [4096];
   logic [95:0] rdata_q = '0;
   bit          mem_init = 1'b0;
   assign RW0_rdata = rdata_q;
   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < 4096; i++) sram_mem[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (RW0_en) begin
         if (RW0_wmode) sram_mem[RW0_addr] <= apply_mask(sram_mem[RW0_addr], RW0_wdata, RW0_wmask);
         else           rdata_q <= sram_mem[RW0_addr];
      end
   end

   // Reference model state
   logic [95:0] ref_mem [4096];
   logic [95:0] exp_data [$];
   int          exp_cyc [$];
   int          m_starve;
   int          cyc;
   bit          prev_en, prev_wm;
   logic [11:0] prev_addr;
   logic [95:0] prev_wdata;
   logic [15:0] prev_mask;
   bit          obs_rr, obs_rv;
   logic [95:0] obs_rd;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: check outputs against the model at negedge, advance the model.
   task automatic cycle();
      int          cnt;
      bit          rd_ok, ovr, exp_wr, exp_rr, wg, rg, rv;
      bit          e_en, e_wm;
      logic [11:0] e_addr;
      logic [95:0] e_wdata;
      logic [15:0] e_mask;
      @(negedge clock);
      obs_rr = r_ready;
      obs_rv = resp_valid;
      obs_rd = resp_data;
      if (reset) begin
         exp_data.delete();
         exp_cyc.delete();
         m_starve = 0;
         prev_en = 0; prev_wm = 0; prev_addr = '0; prev_wdata = '0; prev_mask = '0;
      end else begin
         cnt    = exp_data.size();
         rd_ok  = cnt < DEPTH;
         ovr    = (m_starve == LIM);
         exp_wr = ovr ? !(r_valid && rd_ok) : 1'b1;
         exp_rr = ovr ? rd_ok : (rd_ok && !w_valid);
         check_eq("w_ready", 96'(w_ready), 96'(exp_wr));
         check_eq("r_ready", 96'(r_ready), 96'(exp_rr));
         wg = w_valid && exp_wr;
         rg = r_valid && exp_rr;
         e_en    = wg || rg;
         e_wm    = wg;
         e_addr  = wg ? w_addr : (rg ? r_addr : 12'h0);
         e_wdata = wg ? w_data : '0;
         e_mask  = wg ? w_mask : '0;
`ifdef SRAM_RW_SCHED_OUTREG_EN
         check_eq("RW0_en",    96'(RW0_en),    96'(prev_en));
         check_eq("RW0_wmode", 96'(RW0_wmode), 96'(prev_wm));
         check_eq("RW0_addr",  96'(RW0_addr),  96'(prev_addr));
         check_eq("RW0_wdata", RW0_wdata,      prev_wdata);
         check_eq("RW0_wmask", 96'(RW0_wmask), 96'(prev_mask));
         prev_en = e_en; prev_wm = e_wm; prev_addr = e_addr; prev_wdata = e_wdata; prev_mask = e_mask;
`else
         check_eq("RW0_en",    96'(RW0_en),    96'(e_en));
         check_eq("RW0_wmode", 96'(RW0_wmode), 96'(e_wm));
         check_eq("RW0_addr",  96'(RW0_addr),  96'(e_addr));
         check_eq("RW0_wdata", RW0_wdata,      e_wdata);
         check_eq("RW0_wmask", 96'(RW0_wmask), 96'(e_mask));
`endif
         rv = (exp_data.size() > 0) && (exp_cyc[0] <= cyc);
         check_eq("resp_valid", 96'(resp_valid), 96'(rv));
         if (rv) check_eq("resp_data", resp_data, exp_data[0]);
         if (rv && resp_ready) begin
            void'(exp_data.pop_front());
            void'(exp_cyc.pop_front());
         end
         if (wg) ref_mem[w_addr] = apply_mask(ref_mem[w_addr], w_data, w_mask);
         if (rg) begin
            exp_data.push_back(ref_mem[r_addr]);
            exp_cyc.push_back(cyc + LAT);
         end
         if (!r_valid || rg) m_starve = 0;
         else if (rd_ok && w_valid && m_starve < LIM) m_starve++;
      end
      cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      w_valid = 0; r_valid = 0; resp_ready = 1;
      for (int i = 0; i < n; i++) cycle();
   endtask

   int acc, first_rv, last_rv, nrv;

   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
      cyc = 0; m_starve = 0;
      reset = 1; w_valid = 0; r_valid = 0; resp_ready = 0;
      w_addr = '0; r_addr = '0; w_data = '0; w_mask = '0;
      @(posedge clock); #1;
      cycle(); cycle();
      reset = 0;

      // Reset state
      @(negedge clock);
      check_eq("rst_w_ready", 96'(w_ready), 96'(1));
      check_eq("rst_r_ready", 96'(r_ready), 96'(1));
      check_eq("rst_resp_valid", 96'(resp_valid), 96'(0));
      check_eq("rst_RW0_en", 96'(RW0_en), 96'(0));
      check_eq("rst_RW0_addr", 96'(RW0_addr), 96'(0));
      @(posedge clock); #1;

      // Single write then read
      resp_ready = 1;
      w_valid = 1; w_addr = 12'h123; w_data = {12{8'hA5}}; w_mask = 16'hFFFF;
      cycle();
      w_valid = 0; r_valid = 1; r_addr = 12'h123;
      cycle();
      r_valid = 0;
      for (int k = 1; k <= LAT; k++) begin
         cycle();
         check_eq("wr_rd_latency", 96'(obs_rv), 96'(k == LAT));
      end
      check_eq("wr_rd_data", obs_rd, {12{8'hA5}});
      idle(3);

      // Contention: W,W,W,W,R repeating
      w_valid = 1; r_valid = 1; resp_ready = 1;
      for (int i = 0; i < 10; i++) begin
         w_addr = 12'(i); w_data = {3{$urandom}}; w_mask = 16'($urandom);
         r_addr = 12'(100 + i);
         cycle();
         check_eq("contend_pattern", 96'(obs_rr), 96'(i % 5 == 4));
      end
      idle(5);

      // Backpressure
      resp_ready = 0; r_valid = 1; acc = 0;
      for (int i = 0; i < 5; i++) begin
         r_addr = 12'(200 + i);
         cycle();
         if (obs_rr) acc++;
      end
      check_eq("bp_accepted", 96'(acc), 96'(DEPTH));
      check_eq("bp_r_ready_full", 96'(obs_rr), 96'(0));
      resp_ready = 1; r_addr = 12'h300;
      cycle();
      r_valid = 0;
      idle(8);

      // Full throughput
      acc = 0; nrv = 0; first_rv = -1; last_rv = -1;
      resp_ready = 1; r_valid = 1;
      for (int i = 0; i < 20 + LAT + 2; i++) begin
         if (i == 20) r_valid = 0;
         r_addr = 12'(400 + i);
         cycle();
         if (obs_rr && i < 20) acc++;
         if (obs_rv) begin
            nrv++;
            if (first_rv < 0) first_rv = i;
            last_rv = i;
         end
      end
      check_eq("tput_accepted", 96'(acc), 96'(20));
      check_eq("tput_responses", 96'(nrv), 96'(20));
      check_eq("tput_consecutive", 96'(last_rv - first_rv), 96'(19));
      idle(3);

      // Reset mid-read
      r_valid = 1; r_addr = 12'h055;
      cycle();
      r_valid = 0; reset = 1;
      cycle();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("rst_mid_no_resp", 96'(obs_rv), 96'(0));
      end
      r_valid = 1; r_addr = 12'h055;
      cycle();
      r_valid = 0;
      for (int k = 1; k <= LAT; k++) cycle();
      check_eq("rst_mid_post_valid", 96'(obs_rv), 96'(1));
      check_eq("rst_mid_post_data", obs_rd, ref_mem[12'h055]);
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         w_valid    = ($urandom_range(0, 2) != 0);
         r_valid    = ($urandom_range(0, 2) != 0);
         w_addr     = 12'($urandom_range(0, 15));
         r_addr     = 12'($urandom_range(0, 15));
         w_data     = {$urandom, $urandom, $urandom};
         w_mask     = 16'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      idle(LAT + DEPTH + 2);
      check_eq("final_drained", 96'(exp_data.size()), 96'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
